// File: rtl/hist_pkg.sv
// Shared definitions for the histogram chain and its collect/drain sequencer.
package hist_pkg;

  localparam int NUM_BINS_DEF = 16;
  localparam int BIN_AW_DEF   = 4;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_DRAIN,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/hist_collect_ctrl_if.sv
// Control, bin access and drain-stream signals between the sequencer and its surroundings.
interface hist_collect_ctrl_if #(
  parameter int BIN_AW = hist_pkg::BIN_AW_DEF,
  parameter int CNT_W  = hist_pkg::CNT_W_DEF,
  parameter int WIN_W  = 32
);
  logic              start;
  logic              abort;
  logic [WIN_W-1:0]  win_len;
  logic              collect;
  logic              busy;
  logic              hist_rd_en;
  logic [BIN_AW-1:0] hist_rd_addr;
  logic [CNT_W-1:0]  hist_rd_data;
  logic              hist_clr_en;
  logic [BIN_AW-1:0] hist_clr_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [BIN_AW-1:0] rd_bin;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_last;
  logic              done;
  logic              aborted;

  modport master (
    input  start, abort, win_len, hist_rd_data, rd_ready,
    output collect, busy, hist_rd_en, hist_rd_addr, hist_clr_en, hist_clr_addr,
           rd_valid, rd_bin, rd_count, rd_last, done, aborted
  );

  modport slave (
    output start, abort, win_len, hist_rd_data, rd_ready,
    input  collect, busy, hist_rd_en, hist_rd_addr, hist_clr_en, hist_clr_addr,
           rd_valid, rd_bin, rd_count, rd_last, done, aborted
  );
endinterface

// File: rtl/hist_win_cnt.sv
// Loadable down-counter with zero flag; times the collect window and the flush gap.
module hist_win_cnt #(
  parameter int W = 32
) (
  input  logic         clk350,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk350 or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/hist_collect_ctrl.sv
// Sequencer for one histogram chain: collect window, pipeline flush, drain over
// a valid/ready stream, then zero-clear of every bin.
module hist_collect_ctrl
  import hist_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int BIN_AW   = BIN_AW_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN_W    = 32,
  parameter int PIPE_LAT = 3
) (
  input  logic                clk350,
  input  logic                rst,
  hist_collect_ctrl_if.master bus
);
  localparam logic [BIN_AW-1:0] LAST_BIN   = BIN_AW'(NUM_BINS - 1);
  localparam logic [WIN_W-1:0]  FLUSH_LOAD = WIN_W'(PIPE_LAT - 1);

  state_e             state_q, state_d;
  logic               abt_q, abt_d;
  logic [BIN_AW-1:0]  addr_q, addr_d;
  logic [BIN_AW-1:0]  clr_addr_q, clr_addr_d;
  logic [BIN_AW-1:0]  rd_bin_q, rd_bin_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;
  logic               rd_en_q, rd_en_d;
  logic               pend_q, pend_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               collect_q, busy_q, clr_en_q, done_q, aborted_q;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [WIN_W-1:0]   cnt_load_val;
  logic               hs_next;
  logic               rd_en;

  hist_win_cnt #(.W(WIN_W)) u_win_cnt (
    .clk350   (clk350),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // A handshake on a non-final beat issues the next read in the same cycle.
  assign hs_next = (state_q == ST_DRAIN) && rd_valid_q && bus.rd_ready && !rd_last_q;
  assign rd_en   = rd_en_q | hs_next;

  // Next-state logic for the run sequence and the drain beat registers.
  always_comb begin
    state_d      = state_q;
    abt_d        = abt_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = FLUSH_LOAD;
    addr_d       = addr_q;
    clr_addr_d   = '0;
    rd_en_d      = 1'b0;
    rd_valid_d   = rd_valid_q;
    rd_bin_d     = rd_bin_q;
    rd_count_d   = rd_count_q;
    rd_last_d    = rd_last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          abt_d    = 1'b0;
          cnt_load = 1'b1;
          if (bus.win_len == '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d      = ST_COLLECT;
            cnt_load_val = bus.win_len - WIN_W'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (bus.abort || cnt_zero) begin
          abt_d    = abt_q | bus.abort;
          state_d  = ST_FLUSH;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FLUSH: begin
        abt_d = abt_q | bus.abort;
        if (cnt_zero) begin
          if (abt_q || bus.abort) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_DRAIN;
            addr_d  = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          abt_d      = 1'b1;
          state_d    = ST_CLEAR;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else begin
          if (rd_valid_q && bus.rd_ready) begin
            rd_valid_d = 1'b0;
            if (rd_last_q) begin
              state_d   = ST_CLEAR;
              rd_last_d = 1'b0;
            end else begin
              addr_d = addr_q + BIN_AW'(1);
            end
          end
          if (pend_q) begin
            rd_valid_d = 1'b1;
            rd_count_d = bus.hist_rd_data;
            rd_bin_d   = addr_q;
            rd_last_d  = (addr_q == LAST_BIN);
          end
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST_BIN) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + BIN_AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = rd_en && (state_d == ST_DRAIN);
  end

  // State, drain and registered output flops.
  always_ff @(posedge clk350 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      abt_q      <= 1'b0;
      addr_q     <= '0;
      clr_addr_q <= '0;
      rd_bin_q   <= '0;
      rd_count_q <= '0;
      rd_en_q    <= 1'b0;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      collect_q  <= 1'b0;
      busy_q     <= 1'b0;
      clr_en_q   <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      abt_q      <= abt_d;
      addr_q     <= addr_d;
      clr_addr_q <= clr_addr_d;
      rd_bin_q   <= rd_bin_d;
      rd_count_q <= rd_count_d;
      rd_en_q    <= rd_en_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      collect_q  <= (state_d == ST_COLLECT);
      busy_q     <= (state_d != ST_IDLE);
      clr_en_q   <= (state_d == ST_CLEAR);
      done_q     <= (state_q == ST_CLEAR) && (state_d == ST_IDLE);
      aborted_q  <= (state_q == ST_CLEAR) && (state_d == ST_IDLE) && abt_q;
    end
  end

  assign bus.collect       = collect_q;
  assign bus.busy          = busy_q;
  assign bus.hist_rd_en    = rd_en;
  assign bus.hist_rd_addr  = hs_next ? (addr_q + BIN_AW'(1)) : addr_q;
  assign bus.hist_clr_en   = clr_en_q;
  assign bus.hist_clr_addr = clr_addr_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_bin        = rd_bin_q;
  assign bus.rd_count      = rd_count_q;
  assign bus.rd_last       = rd_last_q;
  assign bus.done          = done_q;
  assign bus.aborted       = aborted_q;
endmodule
